// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register with a valid/ready handshake, an optional 1-entry skid
// buffer, and a synchronous flush that turns held entries into bubbles.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 96,
    parameter int unsigned CTRL_W   = 1,
    parameter bit          SKID_EN  = 1'b1,
    parameter bit          CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q,  head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q,  head_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    logic push;
    logic pop;

    // With the skid buffer, ready depends only on state, never on out_ready.
    assign in_ready = SKID_EN ? !skid_valid_q : (!head_valid_q || out_ready);
    assign push     = in_valid && in_ready;
    assign pop      = head_valid_q && out_ready;

    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_ctrl_d  = head_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            // Any same-cycle pop has already been consumed downstream; any push is dropped.
            head_valid_d = 1'b0;
            head_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            if (CLR_DATA) begin
                head_data_d = '0;
                skid_data_d = '0;
            end
        end else if (pop && skid_valid_q) begin
            // in_ready is low whenever the skid is full, so no push can coincide here.
            head_valid_d = 1'b1;
            head_data_d  = skid_data_q;
            head_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            if (CLR_DATA) begin
                skid_data_d = '0;
            end
        end else if (push && (!head_valid_q || pop)) begin
            head_valid_d = 1'b1;
            head_data_d  = in_data;
            head_ctrl_d  = in_ctrl;
        end else if (pop) begin
            head_valid_d = 1'b0;
            head_ctrl_d  = '0;
            if (CLR_DATA) begin
                head_data_d = '0;
            end
        end else if (SKID_EN && push && head_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_ctrl_q  <= head_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;
    // A bubble must never drive a write enable, whatever is stored.
    assign out_ctrl  = head_ctrl_q & {CTRL_W{head_valid_q}};
    assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register for the RISC-V core, replacing the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single reusable block.
- Carries a payload split into a data field and a control field (write enables and similar) across one stage, using a valid/ready handshake instead of a global stall vector.
- Optional 1-entry skid buffer breaks the combinational ready path.
- A synchronous flush kills in-flight entries and turns them into bubbles; a bubble never presents active control bits downstream.

Parameters:
- DATA_W, 96, width of the data payload (e.g. pc, ALU result, store data).
- CTRL_W, 1, width of the control payload (e.g. mem write enable); forced to 0 whenever the stage output is not valid.
- SKID_EN, 1, 1 = registered ready with 1-entry skid buffer; 0 = single register, combinational ready.
- CLR_DATA, 1, 1 = data field zeroed on flush and on pop-to-empty; 0 = data field holds its last value.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous kill of all entries held in this stage.
- in_valid, in, 1, upstream has an entry.
- in_ready, out, 1, stage can accept an entry this cycle.
- in_data, in, DATA_W, upstream data payload.
- in_ctrl, in, CTRL_W, upstream control payload.
- out_valid, out, 1, stage holds a valid entry.
- out_ready, in, 1, downstream accepts the entry this cycle.
- out_data, out, DATA_W, data payload of the head entry.
- out_ctrl, out, CTRL_W, control payload of the head entry, ANDed with out_valid.
- occupancy, out, 2, number of entries held (0..2; max 1 when SKID_EN=0).

Behaviour:
- Reset (rst_n=0, asynchronous): all storage valid bits, out_valid, out_ctrl, out_data and occupancy are 0. in_ready reads 1 while in reset and after it.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
  - Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- SKID_EN=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Simultaneous pop and push replaces the entry, so back-to-back throughput is 1 entry per cycle.
- SKID_EN=1:
  - Storage is a main register (head) plus a skid register. in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
  - Push while the head is empty, or while the head is popping with the skid empty: the entry goes to the head.
  - Push while the head is full and not popping: the entry goes to the skid.
  - Pop with the skid full: the skid moves to the head the same edge, and the skid is then empty.
  - Push and pop in the same cycle with the skid full cannot happen, because in_ready=0.
  - Ordering is strictly FIFO. No entry is ever dropped or duplicated without a flush.
- Flush (flush=1 at an edge):
  - Clears the head and skid valid bits and all stored ctrl bits. The data field is zeroed if CLR_DATA=1.
  - Any input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still completes; the downstream has consumed that entry.
  - After the edge, occupancy=0 and in_ready=1.
  - flush takes priority over every other event.
- Bubble: when out_valid=0, out_ctrl=0 regardless of stored contents. This is a hard requirement: a bubble must never assert a write enable.
- Pop to empty: if CLR_DATA=1, out_data=0 while out_valid=0.
- out_data and out_ctrl are stable while out_valid=1 and out_ready=0 (no change until the transfer).
- in_valid and in_data may change freely when in_ready=0; they are sampled only on a transfer.
- Reset asserted mid-operation: state clears immediately, without waiting for a clock edge. After deassertion, the first valid input appears on the output 1 cycle after acceptance.
- occupancy = head_valid + skid_valid, updated at the same edge as the transfers.

Test Plan:
- Reset: drive in_valid=1 and in_ctrl=1 with rst_n=0 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1. Release reset and push data=0x1234 -> out_data=0x1234 one cycle later.
- Streaming, SKID_EN=1: out_ready=1, push 8 entries data=1..8 back-to-back -> out_data=1..8 on consecutive cycles, occupancy stays at 1 in steady state, in_ready=1 throughout.
- Backpressure: out_ready=0 while pushing A=0xA, B=0xB, C=0xC -> A at head, B in skid, occupancy=2, in_ready=0, C not accepted. Raise out_ready -> outputs A, B, C in order with no loss.
- Flush with skid full: occupancy=2, ctrl=1 on both entries, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, out_data=0 (CLR_DATA=1), and the input entry does not appear later.
- SKID_EN=0: out_ready=0 -> in_ready=0 in the same cycle. Push and pop in the same cycle with data=5 then 6 -> out_data=6 next cycle, occupancy=1.
- Asynchronous reset mid-stream: assert rst_n=0 between edges while occupancy=2 -> out_valid and occupancy go to 0 before the next edge.
